image_blit: RTL and testbench
=============================

IMAGE_BLIT -- requirements
Module: image_blit

Interface
REQ-001 SHALL have parameter SRC_W, default 64, source image width in pixels.
REQ-002 SHALL have parameter SRC_H, default 64, source image height in pixels.
REQ-003 SHALL have parameter DST_W, default 640, destination frame width in pixels.
REQ-004 SHALL have parameter DST_H, default 480, destination frame height in pixels.
REQ-005 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-006 SHALL have parameter KEY, default 8'h00, transparent colour used when REQ-029 is compiled in.
REQ-007 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1, one-cycle blit request.
REQ-010 SHALL have ports x0 (input, clog2(DST_W)) and y0 (input, clog2(DST_H)), destination top-left, sampled with start.
REQ-011 SHALL have port scale, input, 3, integer upscale factor, sampled with start.
REQ-012 SHALL have ports s_addr (output, clog2(SRC_W*SRC_H)) and s_dout (input, PIX_W) to a synchronous source ROM with 1-cycle read latency.
REQ-013 SHALL have ports we (output, 1), addr (output, clog2(DST_W*DST_H)) and dout (output, PIX_W), frame-buffer write port.
REQ-014 SHALL have ports busy (output, 1, blit in progress) and done (output, 1, one-cycle completion pulse).

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on start; RUN->DRAIN after the last source read is issued; DRAIN->IDLE after the last write slot.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL treat scale=0 as scale=1.
REQ-018 SHALL issue one source read per RUN cycle, scanning destination-relative coordinates dx=0..SRC_W*scale-1 within rows dy=0..SRC_H*scale-1, row-major.
REQ-019 SHALL drive s_addr=(dy/scale)*SRC_W+(dx/scale) using repeat sub-counters, with no divider or multiplier in the loop.
REQ-020 SHALL present we/addr/dout exactly one cycle after the corresponding s_addr, with addr=(y0+dy)*DST_W+(x0+dx) and dout=s_dout.
REQ-021 SHALL hold addr as an incremental register: +1 per dx step, advanced to the next row start at the end of each row.
REQ-022 SHALL force we=0 (clipping) for any pixel with x0+dx>=DST_W or y0+dy>=DST_H, while the scan still runs its full length.
REQ-023 SHALL assert busy from the cycle after start until DRAIN exits, and pulse done for one cycle in the cycle after the final write slot.
REQ-024 SHALL make the run length exactly SRC_W*SRC_H*scale^2 write slots, independent of clipping.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force state=IDLE, we=0, busy=0, done=0, addr=0, s_addr=0, dout=0 and all counters to 0.
REQ-026 SHALL abort a blit on reset mid-operation with no further writes, and SHALL NOT resume it after reset release.
REQ-027 SHALL accept a start in the first cycle after reset release.

Configuration
REQ-028 SHALL gate colour-key transparency with macro IMAGE_BLIT_KEY_EN.
REQ-029 SHALL, with IMAGE_BLIT_KEY_EN defined, suppress we for any slot where s_dout==KEY; without it, SHALL write every unclipped pixel regardless of value.

Verification
REQ-030 SHALL cover: x0=0, y0=0, scale=1 -> 4096 writes; first addr=0, dout=ROM[0]; last addr=40383, dout=ROM[4095]; done one cycle after.
REQ-031 SHALL cover: x0=10, y0=20, scale=2 -> 16384 writes; addr 12810, 12811, 13450 and 13451 all carry ROM[0]; addr 12812 carries ROM[1].
REQ-032 SHALL cover: x0=600, y0=0, scale=1 -> 2560 writes (columns 600..639 only); busy lasts 4096+1 cycles.
REQ-033 SHALL cover: start pulsed mid-blit -> ignored, with the write count unchanged; rst_n=0 at write 100 -> we=0 immediately, busy=0, no done pulse.
REQ-034 SHALL cover: ROM[5]=KEY, scale=1 at origin -> with IMAGE_BLIT_KEY_EN, no write to addr 5 (4095 writes); without it, 4096 writes.
REQ-035 SHALL cover: scale=0 -> behaves as scale=1 (4096 writes).

Source files
------------

// File: rtl/image_blit.sv
// Scaled sprite blit from a synchronous source ROM into a frame buffer.
// Optional colour-key transparency is compiled in with IMAGE_BLIT_KEY_EN.
module image_blit #(
  parameter int         SRC_W = 64,
  parameter int         SRC_H = 64,
  parameter int         DST_W = 640,
  parameter int         DST_H = 480,
  parameter int         PIX_W = 8,
  parameter logic [7:0] KEY   = 8'h00
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(DST_W)-1:0]         x0,
  input  logic [$clog2(DST_H)-1:0]         y0,
  input  logic [2:0]                       scale,
  output logic [$clog2(SRC_W*SRC_H)-1:0]   s_addr,
  input  logic [PIX_W-1:0]                 s_dout,
  output logic                             we,
  output logic [$clog2(DST_W*DST_H)-1:0]   addr,
  output logic [PIX_W-1:0]                 dout,
  output logic                             busy,
  output logic                             done
);

  localparam int SAW = $clog2(SRC_W*SRC_H);
  localparam int DAW = $clog2(DST_W*DST_H);
  localparam int SXW = $clog2(SRC_W);
  localparam int SYW = $clog2(SRC_H);
  localparam int CXW = $clog2(DST_W + 8*SRC_W);
  localparam int CYW = $clog2(DST_H + 8*SRC_H);
`ifdef IMAGE_BLIT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state_q;
  logic [2:0]     scl_q, rx_q, ry_q;
  logic [SXW-1:0] sx_q;
  logic [SYW-1:0] sy_q;
  logic [CXW-1:0] x0_q, cx_q;
  logic [CYW-1:0] cy_q;
  logic [SAW-1:0] s_addr_q, srow_q;
  logic [DAW-1:0] daddr_q, drow_q, addr_q;
  logic           wv_q, slot_q, busy_q, done_q;

  logic           x_last, y_last;
  logic [DAW-1:0] start_addr_d;

  assign x_last = (sx_q == SXW'(SRC_W-1)) && (rx_q == scl_q - 3'd1);
  assign y_last = (sy_q == SYW'(SRC_H-1)) && (ry_q == scl_q - 3'd1);
  // The only multiply happens once, when the blit is armed.
  assign start_addr_d = DAW'(y0) * DAW'(DST_W) + DAW'(x0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      scl_q    <= '0;
      rx_q     <= '0;
      ry_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      x0_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      s_addr_q <= '0;
      srow_q   <= '0;
      daddr_q  <= '0;
      drow_q   <= '0;
      addr_q   <= '0;
      wv_q     <= 1'b0;
      slot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      slot_q <= 1'b0;
      wv_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            scl_q    <= (scale == 3'd0) ? 3'd1 : scale;
            x0_q     <= CXW'(x0);
            cx_q     <= CXW'(x0);
            cy_q     <= CYW'(y0);
            rx_q     <= '0;
            ry_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
            s_addr_q <= '0;
            srow_q   <= '0;
            daddr_q  <= start_addr_d;
            drow_q   <= start_addr_d;
          end
        end
        RUN: begin
          slot_q <= 1'b1;
          addr_q <= daddr_q;
          wv_q   <= (cx_q < CXW'(DST_W)) && (cy_q < CYW'(DST_H));
          if (x_last && y_last) begin
            state_q <= DRAIN;
          end else if (x_last) begin
            cx_q    <= x0_q;
            cy_q    <= cy_q + CYW'(1);
            sx_q    <= '0;
            rx_q    <= '0;
            drow_q  <= drow_q + DAW'(DST_W);
            daddr_q <= drow_q + DAW'(DST_W);
            // Repeat the same source row until scale destination rows are done.
            if (ry_q == scl_q - 3'd1) begin
              ry_q     <= '0;
              sy_q     <= sy_q + SYW'(1);
              srow_q   <= srow_q + SAW'(SRC_W);
              s_addr_q <= srow_q + SAW'(SRC_W);
            end else begin
              ry_q     <= ry_q + 3'd1;
              s_addr_q <= srow_q;
            end
          end else begin
            cx_q    <= cx_q + CXW'(1);
            daddr_q <= daddr_q + DAW'(1);
            if (rx_q == scl_q - 3'd1) begin
              rx_q     <= '0;
              sx_q     <= sx_q + SXW'(1);
              s_addr_q <= s_addr_q + SAW'(1);
            end else begin
              rx_q <= rx_q + 3'd1;
            end
          end
        end
        DRAIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ROM data lands in the write slot itself, so the key test and data path are combinational.
  assign we     = wv_q && !(KEY_EN && (s_dout == PIX_W'(KEY)));
  assign dout   = slot_q ? s_dout : '0;
  assign addr   = addr_q;
  assign s_addr = s_addr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_image_blit.sv
// Directed bench for image_blit: ROM model, frame-buffer capture and per-write data check.
module tb_image_blit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  x0 = '0;
  logic [8:0]  y0 = '0;
  logic [2:0]  scale = 3'd1;
  logic [11:0] s_addr;
  logic [7:0]  s_dout;
  logic        we;
  logic [18:0] addr;
  logic [7:0]  dout;
  logic        busy;
  logic        done;

  image_blit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .y0(y0), .scale(scale),
    .s_addr(s_addr), .s_dout(s_dout), .we(we), .addr(addr), .dout(dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [0:4095];
  logic [7:0] fb  [0:307199];

  always @(posedge clk) s_dout <= rom[s_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt, busy_cnt, done_cnt, data_err;
  int first_addr, first_dout, last_addr, last_dout, last_we_cyc, done_cyc;
  int cur_x0, cur_y0, cur_s;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    int px, py;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (we === 1'b1) begin
      if (wr_cnt == 0) begin
        first_addr = int'(addr);
        first_dout = int'(dout);
      end
      last_addr = int'(addr);
      last_dout = int'(dout);
      last_we_cyc = cyc;
      wr_cnt++;
      fb[int'(addr)] = dout;
      px = int'(addr) % 640 - cur_x0;
      py = int'(addr) / 640 - cur_y0;
      if (px < 0 || py < 0 || px >= 64*cur_s || py >= 64*cur_s || px + cur_x0 >= 640)
        data_err++;
      else if (dout !== rom[(py/cur_s)*64 + px/cur_s])
        data_err++;
    end
  end

  // Caller positions at a negedge; start is high for exactly one cycle.
  task automatic start_blit(input int x, input int y, input int s);
    cur_x0 = x; cur_y0 = y; cur_s = (s == 0) ? 1 : s;
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; data_err = 0;
    last_we_cyc = -1; done_cyc = -100;
    x0 = 10'(x); y0 = 9'(y); scale = 3'(s);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s done_timeout: done not seen within 20000 cycles", name);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (we !== 1'b0)   begin errors++; $display("FAIL reset_we: got %b want 0", we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (addr !== '0)   begin errors++; $display("FAIL reset_addr: got %0d want 0", addr); end
    checks++; if (s_addr !== '0) begin errors++; $display("FAIL reset_s_addr: got %0d want 0", s_addr); end
    checks++; if (dout !== '0)   begin errors++; $display("FAIL reset_dout: got %0d want 0", dout); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_origin;
    start_blit(0, 0, 1);
    wait_done("origin");
    checks++; if (wr_cnt != 4096) begin errors++; $display("FAIL origin_count: got %0d want 4096", wr_cnt); end
    checks++; if (first_addr != 0) begin errors++; $display("FAIL origin_first_addr: got %0d want 0", first_addr); end
    checks++; if (first_dout != int'(rom[0])) begin errors++; $display("FAIL origin_first_dout: got %0d want %0d", first_dout, rom[0]); end
    checks++; if (last_addr != 40383) begin errors++; $display("FAIL origin_last_addr: got %0d want 40383", last_addr); end
    checks++; if (last_dout != int'(rom[4095])) begin errors++; $display("FAIL origin_last_dout: got %0d want %0d", last_dout, rom[4095]); end
    checks++; if (done_cyc != last_we_cyc + 1) begin errors++; $display("FAIL origin_done_timing: got cycle %0d want %0d", done_cyc, last_we_cyc + 1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL origin_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (busy_cnt != 4097) begin errors++; $display("FAIL origin_busy_len: got %0d want 4097", busy_cnt); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL origin_data: got %0d bad writes want 0", data_err); end
  endtask

  task automatic test_scale2;
    @(negedge clk);
    start_blit(10, 20, 2);
    wait_done("scale2");
    checks++; if (wr_cnt != 16384) begin errors++; $display("FAIL scale2_count: got %0d want 16384", wr_cnt); end
    checks++; if (fb[12810] !== rom[0]) begin errors++; $display("FAIL scale2_12810: got %0d want %0d", fb[12810], rom[0]); end
    checks++; if (fb[12811] !== rom[0]) begin errors++; $display("FAIL scale2_12811: got %0d want %0d", fb[12811], rom[0]); end
    checks++; if (fb[13450] !== rom[0]) begin errors++; $display("FAIL scale2_13450: got %0d want %0d", fb[13450], rom[0]); end
    checks++; if (fb[13451] !== rom[0]) begin errors++; $display("FAIL scale2_13451: got %0d want %0d", fb[13451], rom[0]); end
    checks++; if (fb[12812] !== rom[1]) begin errors++; $display("FAIL scale2_12812: got %0d want %0d", fb[12812], rom[1]); end
    checks++; if (busy_cnt != 16385) begin errors++; $display("FAIL scale2_busy_len: got %0d want 16385", busy_cnt); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL scale2_data: got %0d bad writes want 0", data_err); end
  endtask

  task automatic test_clip;
    @(negedge clk);
    start_blit(600, 0, 1);
    wait_done("clip");
    checks++; if (wr_cnt != 2560) begin errors++; $display("FAIL clip_count: got %0d want 2560", wr_cnt); end
    checks++; if (busy_cnt != 4097) begin errors++; $display("FAIL clip_busy_len: got %0d want 4097", busy_cnt); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL clip_data: got %0d bad writes want 0", data_err); end
  endtask

  task automatic test_back_to_back;
    bit seen = 1'b0;
    @(negedge clk);
    start_blit(0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (wr_cnt >= 500) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_progress: got %0d writes want >=500", wr_cnt); end
    x0 = 10'd5; scale = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b");
    checks++; if (wr_cnt != 4096) begin errors++; $display("FAIL b2b_count: got %0d want 4096", wr_cnt); end
    checks++; if (busy_cnt != 4097) begin errors++; $display("FAIL b2b_busy_len: got %0d want 4097", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL b2b_data: got %0d bad writes want 0", data_err); end
  endtask

  task automatic test_key;
    int exp_cnt;
    logic [7:0] saved;
    saved = rom[5];
    rom[5] = 8'h00;
`ifdef IMAGE_BLIT_KEY_EN
    exp_cnt = 4095;
`else
    exp_cnt = 4096;
`endif
    @(negedge clk);
    start_blit(0, 0, 1);
    wait_done("key");
    checks++; if (wr_cnt != exp_cnt) begin errors++; $display("FAIL key_count: got %0d want %0d", wr_cnt, exp_cnt); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL key_data: got %0d bad writes want 0", data_err); end
    rom[5] = saved;
  endtask

  task automatic test_scale0;
    @(negedge clk);
    start_blit(0, 0, 0);
    wait_done("scale0");
    checks++; if (wr_cnt != 4096) begin errors++; $display("FAIL scale0_count: got %0d want 4096", wr_cnt); end
    checks++; if (last_addr != 40383) begin errors++; $display("FAIL scale0_last_addr: got %0d want 40383", last_addr); end
    checks++; if (data_err != 0) begin errors++; $display("FAIL scale0_data: got %0d bad writes want 0", data_err); end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    @(negedge clk);
    start_blit(0, 0, 1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (wr_cnt >= 100) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL abort_progress: got %0d writes want 100", wr_cnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (we !== 1'b0)   begin errors++; $display("FAIL abort_we: got %b want 0", we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (wr_cnt != 100) begin errors++; $display("FAIL abort_no_resume: got %0d writes want 100", wr_cnt); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_start_after_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start_blit(0, 0, 1);
    wait_done("post_reset");
    checks++; if (wr_cnt != 4096) begin errors++; $display("FAIL post_reset_count: got %0d want 4096", wr_cnt); end
    checks++; if (busy_cnt != 4097) begin errors++; $display("FAIL post_reset_busy_len: got %0d want 4097", busy_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'((i % 255) + 1);
    cur_x0 = 0; cur_y0 = 0; cur_s = 1;
    wr_cnt = 0; busy_cnt = 0; done_cnt = 0; data_err = 0;
    test_reset();
    test_origin();
    test_scale2();
    test_clip();
    test_back_to_back();
    test_key();
    test_scale0();
    test_reset_mid();
    test_start_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
